// File: rtl/sym_packer_pkg.sv
// Shared constants and types for the symbol-to-byte packer.
package sym_packer_pkg;

    localparam int SYM_W  = 3;
    localparam int BYTE_W = 8;
    localparam int ACC_W  = BYTE_W - 1 + SYM_W;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] PAY_BITS_2 = CNT_W'(2);
    localparam logic [CNT_W-1:0] PAY_BITS_3 = CNT_W'(3);
    localparam logic [CNT_W-1:0] CNT_BYTE   = CNT_W'(BYTE_W);

    typedef enum logic [0:0] {
        ST_ACC,
        ST_FLUSH_PEND
    } pk_state_e;

    // Left-justify the n (1..7) valid low bits of acc into a byte, zero-padding the LSBs.
    function automatic logic [BYTE_W-1:0] pad_residue(
        input logic [ACC_W-1:0] acc,
        input logic [CNT_W-1:0] n
    );
        return BYTE_W'(acc << (CNT_BYTE - n));
    endfunction

endpackage

// File: rtl/sym_packer_if.sv
// Symbol-in / byte-out bus of the packer.
interface sym_packer_if;
    import sym_packer_pkg::*;

    logic [SYM_W-1:0]  sym_in;
    logic              sym_valid;
    logic              bit4;
    logic              flush;
    logic              hold;
    logic [BYTE_W-1:0] DB;
    logic              wr;
    logic              overflow;

    modport master (
        output sym_in, sym_valid, bit4, flush, hold,
        input  DB, wr, overflow
    );

    modport slave (
        input  sym_in, sym_valid, bit4, flush, hold,
        output DB, wr, overflow
    );
endinterface

// File: rtl/sym_out_buf.sv
// Single-byte output register: holds a packed byte until the downstream takes it,
// flags a sticky overflow when a new byte arrives while the held one is stalled.
module sym_out_buf
    import sym_packer_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] byte_i,
    input  logic              hold_i,
    output logic [BYTE_W-1:0] db_o,
    output logic              wr_o,
    output logic              overflow_o
);
    logic              full_q, full_d;
    logic [BYTE_W-1:0] db_q, db_d;
    logic              ovf_q, ovf_d;
    logic              wr;

    // Load/drain/drop decision for the held byte.
    always_comb begin
        wr     = full_q & ~hold_i;
        full_d = full_q;
        db_d   = db_q;
        ovf_d  = ovf_q;
        if (load_i) begin
            if (!full_q || wr) begin
                db_d   = byte_i;
                full_d = 1'b1;
            end else begin
                ovf_d  = 1'b1;
            end
        end else if (wr) begin
            full_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            full_q <= 1'b0;
            db_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            full_q <= full_d;
            db_q   <= db_d;
            ovf_q  <= ovf_d;
        end
    end

    assign db_o       = db_q;
    assign wr_o       = wr;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sym_packer.sv
// Packs 3-bit symbols (3 or 2 payload bits each) MSB-first into bytes, with flush
// of partial bytes and a one-byte output buffer.
module sym_packer
    import sym_packer_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    sym_packer_if.slave bus
);
    pk_state_e         state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bit4_q;

    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_abs;
    logic [ACC_W-1:0]  acc_abs;
    logic              emit;
    logic [BYTE_W-1:0] emit_byte;

    // Mode-change discard, pending residue, symbol absorb, then byte/flush emission.
    // A pending residue is taken before the new symbol so that symbol starts a fresh byte;
    // at most one byte leaves per cycle because a fresh symbol alone never fills a byte.
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_byte = '0;
        cnt_base  = (bus.bit4 != bit4_q) ? '0 : cnt_q;
        acc_abs   = acc_q;

        if (state_q == ST_FLUSH_PEND) begin
            if (cnt_base != '0) begin
                emit      = 1'b1;
                emit_byte = pad_residue(acc_q, cnt_base);
            end
            cnt_base = '0;
            state_d  = ST_ACC;
        end

        cnt_abs = cnt_base;
        if (bus.sym_valid) begin
            if (bus.bit4) begin
                acc_abs = {acc_q[ACC_W-3:0], bus.sym_in[1:0]};
                cnt_abs = cnt_base + PAY_BITS_2;
            end else begin
                acc_abs = {acc_q[ACC_W-4:0], bus.sym_in};
                cnt_abs = cnt_base + PAY_BITS_3;
            end
        end

        if (state_q == ST_ACC) begin
            if (cnt_abs >= CNT_BYTE) begin
                emit      = 1'b1;
                emit_byte = BYTE_W'(acc_abs >> (cnt_abs - CNT_BYTE));
                cnt_abs   = cnt_abs - CNT_BYTE;
                if (bus.flush) begin
                    state_d = ST_FLUSH_PEND;
                end
            end else if (bus.flush && cnt_abs != '0) begin
                emit      = 1'b1;
                emit_byte = pad_residue(acc_abs, cnt_abs);
                cnt_abs   = '0;
            end
        end

        acc_d = acc_abs;
        cnt_d = cnt_abs;
    end

    // Packer state registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            bit4_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bit4_q  <= bus.bit4;
        end
    end

    sym_out_buf u_out_buf (
        .Clk        (Clk),
        .Rst        (Rst),
        .load_i     (emit),
        .byte_i     (emit_byte),
        .hold_i     (bus.hold),
        .db_o       (bus.DB),
        .wr_o       (bus.wr),
        .overflow_o (bus.overflow)
    );

endmodule

// File: tb/tb_sym_packer.sv
// Self-checking bench for sym_packer: directed scenarios plus random traffic,
// compared against a bit-queue reference model.
module tb_sym_packer;
    logic Clk;
    logic Rst;
    sym_packer_if bus ();

    sym_packer dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: pending payload bits (oldest first) and output buffer.
    int         bits[$];
    bit         m_b4;
    bit         m_pend;
    bit         m_full;
    logic [7:0] m_db;
    bit         m_ovf;
    logic       wr_pre;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] take(input int n);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], (i < n) ? bits.pop_front() != 0 : 1'b0};
        end
        return b;
    endfunction

    task automatic model_reset();
        bits.delete();
        m_b4   = 1'b0;
        m_pend = 1'b0;
        m_full = 1'b0;
        m_db   = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input bit sv, input logic [2:0] sym, input bit b4,
                              input bit fl, input bit hl);
        bit         emit;
        bit         was_pend;
        bit         wr_now;
        logic [7:0] ob;
        emit = 1'b0;
        ob   = '0;
        if (b4 != m_b4) bits.delete();
        m_b4     = b4;
        was_pend = m_pend;
        m_pend   = 1'b0;
        if (was_pend && bits.size() > 0) begin
            ob   = take(bits.size());
            emit = 1'b1;
        end
        if (sv) begin
            if (!b4) bits.push_back(int'(sym[2]));
            bits.push_back(int'(sym[1]));
            bits.push_back(int'(sym[0]));
        end
        if (!was_pend) begin
            if (bits.size() >= 8) begin
                ob   = take(8);
                emit = 1'b1;
                if (fl) m_pend = 1'b1;
            end else if (fl && bits.size() > 0) begin
                ob   = take(bits.size());
                emit = 1'b1;
            end
        end
        wr_now = m_full && !hl;
        if (emit) begin
            if (!m_full || wr_now) begin
                m_db   = ob;
                m_full = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (wr_now) begin
            m_full = 1'b0;
        end
    endtask

    // One clock: drive, check wr before the edge, advance model, check after the edge.
    task automatic cycle(input bit sv, input logic [2:0] sym, input bit b4,
                         input bit fl, input bit hl);
        bus.sym_valid = sv;
        bus.sym_in    = sym;
        bus.bit4      = b4;
        bus.flush     = fl;
        bus.hold      = hl;
        #1;
        wr_pre = bus.wr;
        chk("wr_pre", 8'(wr_pre), 8'(m_full && !hl));
        @(posedge Clk);
        model_step(sv, sym, b4, fl, hl);
        #1;
        chk("db", bus.DB, m_db);
        chk("wr", 8'(bus.wr), 8'(m_full && !hl));
        chk("ovf", 8'(bus.overflow), 8'(m_ovf));
    endtask

    task automatic do_reset();
        Rst           = 1'b0;
        bus.sym_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;
        #1;
        chk("rst_db", bus.DB, 8'h00);
        chk("rst_wr", 8'(bus.wr), 8'h00);
        chk("rst_ovf", 8'(bus.overflow), 8'h00);
        model_reset();
        #2;
        Rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst           = 1'b0;
        bus.sym_in    = '0;
        bus.sym_valid = 1'b0;
        bus.bit4      = 1'b0;
        bus.flush     = 1'b0;
        bus.hold      = 1'b0;
        model_reset();
        @(posedge Clk);
        #1;
        do_reset();

        // 1: 3-bit mode, 101 011 110 -> AF, then flush of the single residue bit -> 00
        cycle(1, 3'b101, 0, 0, 0);
        cycle(1, 3'b011, 0, 0, 0);
        cycle(1, 3'b110, 0, 0, 0);
        chk("t1_db", bus.DB, 8'hAF);
        chk("t1_wr", 8'(bus.wr), 8'h01);
        cycle(0, 3'b000, 0, 1, 0);
        chk("t1_flush_db", bus.DB, 8'h00);
        chk("t1_flush_wr", 8'(bus.wr), 8'h01);
        cycle(0, 3'b000, 0, 0, 0);

        // 2: 2-bit mode, sym_in[2] ignored -> C9
        cycle(1, 3'b111, 1, 0, 0);
        cycle(1, 3'b000, 1, 0, 0);
        cycle(1, 3'b010, 1, 0, 0);
        chk("t2_wr_early", 8'(bus.wr), 8'h00);
        cycle(1, 3'b001, 1, 0, 0);
        chk("t2_db", bus.DB, 8'hC9);
        chk("t2_wr", 8'(bus.wr), 8'h01);
        cycle(0, 3'b000, 1, 0, 0);

        // 3: hold stalls the first byte, second byte dropped -> overflow; one wr on release
        for (int r = 0; r < 2; r++) begin
            cycle(1, 3'b111, 1, 0, 1);
            cycle(1, 3'b000, 1, 0, 1);
            cycle(1, 3'b010, 1, 0, 1);
            cycle(1, 3'b001, 1, 0, 1);
        end
        chk("t3_ovf", 8'(bus.overflow), 8'h01);
        chk("t3_wr_held", 8'(bus.wr), 8'h00);
        cycle(0, 3'b000, 1, 0, 0);
        chk("t3_wr_release", 8'(wr_pre), 8'h01);
        chk("t3_db", bus.DB, 8'hC9);
        cycle(0, 3'b000, 1, 0, 0);
        chk("t3_no_second_wr", 8'(wr_pre), 8'h00);

        // 4: reset mid-stream, then a clean C9
        cycle(1, 3'b111, 1, 0, 0);
        cycle(1, 3'b000, 1, 0, 0);
        do_reset();
        cycle(1, 3'b111, 1, 0, 0);
        cycle(1, 3'b000, 1, 0, 0);
        cycle(1, 3'b010, 1, 0, 0);
        cycle(1, 3'b001, 1, 0, 0);
        chk("t4_db", bus.DB, 8'hC9);
        cycle(0, 3'b000, 1, 0, 0);

        // 5: mode toggle discards the 2-bit partial; 3-bit symbols give AF
        cycle(1, 3'b111, 1, 0, 0);
        cycle(1, 3'b000, 1, 0, 0);
        cycle(1, 3'b101, 0, 0, 0);
        cycle(1, 3'b011, 0, 0, 0);
        cycle(1, 3'b110, 0, 0, 0);
        chk("t5_db", bus.DB, 8'hAF);
        cycle(0, 3'b000, 0, 1, 0);
        cycle(0, 3'b000, 0, 0, 0);

        // 6: flush on the byte-completing symbol -> FF, then padded residue 80
        cycle(1, 3'b111, 0, 0, 0);
        cycle(1, 3'b111, 0, 0, 0);
        cycle(1, 3'b111, 0, 1, 0);
        chk("t6_db_full", bus.DB, 8'hFF);
        chk("t6_wr_full", 8'(bus.wr), 8'h01);
        cycle(0, 3'b000, 0, 0, 0);
        chk("t6_db_pend", bus.DB, 8'h80);
        chk("t6_wr_pend", 8'(bus.wr), 8'h01);
        cycle(0, 3'b000, 0, 0, 0);

        // Random traffic against the model
        do_reset();
        begin
            bit b4r;
            b4r = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 15) == 0) b4r = ~b4r;
                cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), b4r,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
                if (i == 200) do_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
